// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl -- register file controller behind an SPI byte slave.
//
// The first byte of each chip-select window is a command:
//   bit7 = 1 read / 0 write, bit6 = auto-increment,
//   bits[5:4] unused, bits[3:0] = start address.
// All following bytes in the window are data bytes.
//   - On a write, each data byte is written to the current address.
//   - On a read, each received byte is a dummy byte, and the reply is
//     presented on data_to_send.
// Registers 0..13 are read/write. Register 14 reads status_in. Register 15
// reads ID_VALUE. Writes to 14 and 15 are dropped.
//
// Optional feature (macro SPI_REG_CTRL_WSTRB_EN): adds wr_strobe/wr_addr,
// which flag each cycle in which cfg_regs updates and the address written.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high
//   cs            SPI chip select (active low, already synchronous to clk)
//   data_ready    byte-received flag from the SPI byte slave
//   received_data received byte, valid while data_ready=1
//   read_ack      one-cycle pulse that clears data_ready in the slave
//   data_to_send  byte the slave shifts out next
//   status_in     live status, readable as register 14
//   cfg_regs      registers 0..13, reg n at bits [8n+7:8n]
//   wr_strobe     (optional) pulses in the cycle cfg_regs updates
//   wr_addr       (optional) address written when wr_strobe is 1
module spi_reg_ctrl #(
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         data_ready,
  input  logic [7:0]   received_data,
  output logic         read_ack,
  output logic [7:0]   data_to_send,
  input  logic [7:0]   status_in,
  output logic [111:0] cfg_regs
`ifdef SPI_REG_CTRL_WSTRB_EN
  ,
  output logic         wr_strobe,
  output logic [3:0]   wr_addr
`endif
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              consume;
  logic [3:0]        addr;
  logic              ainc;
  logic              rd_load_p1;
  logic [13:0][7:0]  regs;
  logic              wr_en;

  // Read mux: live status and the ID constant sit above the storage.
  function automatic logic [7:0] rd_value(input logic [3:0]       a,
                                          input logic [13:0][7:0] r,
                                          input logic [7:0]       st);
    logic [7:0] v;
    case (a)
      4'd14:   v = st;
      4'd15:   v = ID_VALUE;
      default: v = r[a];
    endcase
    return v;
  endfunction

  // A byte is taken only if it was not acknowledged in the previous cycle,
  // so read_ack can never stay high for two cycles while data_ready is
  // still clearing in the slave.
  assign consume  = data_ready & ~read_ack & ~cs & (state != IDLE);
  assign wr_en    = (state == WDATA) & consume & (addr < 4'd14);
  assign cfg_regs = regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CMD;
        CMD:     if (consume) state_nxt = received_data[7] ? RDATA : WDATA;
        default: state_nxt = state;
      endcase
    end
  end

  // Stage p0 -> p1: byte consumption, address update, register write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_ack   <= 1'b0;
      addr       <= 4'd0;
      ainc       <= 1'b0;
      rd_load_p1 <= 1'b0;
      regs       <= '0;
    end else begin
      read_ack   <= consume;
      rd_load_p1 <= 1'b0;
      if (consume) begin
        case (state)
          CMD: begin
            addr       <= received_data[3:0];
            ainc       <= received_data[6];
            rd_load_p1 <= received_data[7];
          end
          WDATA: begin
            if (wr_en) regs[addr] <= received_data;
            if (ainc)  addr <= addr + 4'd1;
          end
          RDATA: begin
            // Reload even without auto-increment so reg 14 is re-sampled.
            if (ainc) addr <= addr + 4'd1;
            rd_load_p1 <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Stage p1 -> p2: present the (already advanced) address on data_to_send
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_to_send <= 8'h00;
    end else if (state_nxt != RDATA) begin
      data_to_send <= 8'h00;
    end else if (rd_load_p1) begin
      data_to_send <= rd_value(addr, regs, status_in);
    end
  end

`ifdef SPI_REG_CTRL_WSTRB_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_strobe <= 1'b0;
      wr_addr   <= 4'd0;
    end else begin
      wr_strobe <= wr_en;
      if (wr_en) wr_addr <= addr;
    end
  end
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cs;
  logic         data_ready;
  logic [7:0]   received_data;
  logic         read_ack;
  logic [7:0]   data_to_send;
  logic [7:0]   status_in;
  logic [111:0] cfg_regs;
`ifdef SPI_REG_CTRL_WSTRB_EN
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  int           wcnt = 0;
  logic [3:0]   last_waddr = 4'd0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int ack_cnt     = 0;
  int double_ack  = 0;
  logic prev_ack  = 1'b0;
  logic [13:0][7:0] exp_regs;

  spi_reg_ctrl #(.ID_VALUE(8'hA5)) dut (
    .clk           (clk),
    .reset         (reset),
    .cs            (cs),
    .data_ready    (data_ready),
    .received_data (received_data),
    .read_ack      (read_ack),
    .data_to_send  (data_to_send),
    .status_in     (status_in),
    .cfg_regs      (cfg_regs)
`ifdef SPI_REG_CTRL_WSTRB_EN
    ,
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_ack) ack_cnt++;
    if (read_ack && prev_ack) double_ack++;
    prev_ack = read_ack;
`ifdef SPI_REG_CTRL_WSTRB_EN
    if (wr_strobe) begin
      wcnt++;
      last_waddr = wr_addr;
    end
`endif
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Present one byte, wait (bounded) for the acknowledge, then clear
  // data_ready like the slave would. Returns 1 cycle after the ack rose.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    @(negedge clk);
    received_data = b;
    data_ready    = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      got = read_ack;
    end
    chk("ack_seen", {111'd0, got}, 112'd1);
    data_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_one_cycle", {111'd0, read_ack}, 112'd0);
  endtask

  initial begin
    reset         = 1'b1;
    cs            = 1'b1;
    data_ready    = 1'b0;
    received_data = 8'h00;
    status_in     = 8'h5A;
    exp_regs      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cfg",  cfg_regs, 112'd0);
    chk("reset_ack",  {111'd0, read_ack}, 112'd0);
    chk("reset_dts",  {104'd0, data_to_send}, 112'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Auto-increment write of regs 2..4
    ack_cnt = 0;
    cs_low();
    send_byte(8'h42);
    chk("wr_dts_zero", {104'd0, data_to_send}, 112'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    cs_high();
    exp_regs[2] = 8'h11; exp_regs[3] = 8'h22; exp_regs[4] = 8'h33;
    chk("burst_write", cfg_regs, exp_regs);
    chk("ack_count4",  ack_cnt, 112'd4);
`ifdef SPI_REG_CTRL_WSTRB_EN
    chk("wstrb_count", wcnt, 112'd3);
    chk("wstrb_addr",  {108'd0, last_waddr}, 112'd4);
`endif

    // Auto-increment read starting at reg 2
    cs_low();
    send_byte(8'hC2);
    chk("rd_r2", {104'd0, data_to_send}, 112'h11);
    send_byte(8'h00);
    chk("rd_r3", {104'd0, data_to_send}, 112'h22);
    send_byte(8'h00);
    chk("rd_r4", {104'd0, data_to_send}, 112'h33);
    send_byte(8'h00);
    chk("rd_r5", {104'd0, data_to_send}, 112'h00);
    cs_high();
    chk("idle_dts_zero", {104'd0, data_to_send}, 112'd0);

    // Reg 0 = 77 so the wrap-around read below sees a distinct value
    cs_low();
    send_byte(8'h00);
    send_byte(8'h77);
    cs_high();
    exp_regs[0] = 8'h77;

    // Write at 13 with wrap: 14/15 ignored, reg 0 untouched
    cs_low();
    send_byte(8'h4D);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    cs_high();
    exp_regs[13] = 8'hAA;
    chk("wr_13_wrap", cfg_regs, exp_regs);

    // Read 14 (status), 15 (ID), wrap to 0
    cs_low();
    send_byte(8'hCE);
    chk("rd_status", {104'd0, data_to_send}, 112'h5A);
    status_in = 8'h3C;
    @(posedge clk);
    #1;
    chk("rd_status_held", {104'd0, data_to_send}, 112'h5A);
    send_byte(8'h00);
    chk("rd_id", {104'd0, data_to_send}, 112'hA5);
    send_byte(8'h00);
    chk("rd_wrap_r0", {104'd0, data_to_send}, 112'h77);
    cs_high();

    // No auto-increment write: both bytes land in reg 5
    cs_low();
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    cs_high();
    exp_regs[5] = 8'h02;
    chk("wr_no_inc", cfg_regs, exp_regs);

    // Command with no data, then a fresh transaction starts with a command
    cs_low();
    send_byte(8'h07);
    cs_high();
    chk("cmd_only_nochange", cfg_regs, exp_regs);
    cs_low();
    send_byte(8'h83);
    chk("new_cmd_rd_r3", {104'd0, data_to_send}, 112'h22);
    send_byte(8'h00);
    chk("rd_no_inc_r3", {104'd0, data_to_send}, 112'h22);
    cs_high();

    // Reset in the middle of a write
    cs_low();
    send_byte(8'h40);
    send_byte(8'h99);
    exp_regs[0] = 8'h99;
    chk("pre_reset_wr", cfg_regs, exp_regs);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_reset_cfg", cfg_regs, 112'd0);
`ifdef SPI_REG_CTRL_WSTRB_EN
    chk("mid_reset_wstrb", {111'd0, wr_strobe}, 112'd0);
`endif
    @(posedge clk);
    #1;
    chk("mid_reset_ack", {111'd0, read_ack}, 112'd0);
    chk("mid_reset_dts", {104'd0, data_to_send}, 112'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_regs = '0;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h02);
    send_byte(8'h5C);
    cs_high();
    exp_regs[2] = 8'h5C;
    chk("post_reset_wr", cfg_regs, exp_regs);

    chk("no_double_ack", double_ack, 112'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter ID_VALUE, default 8'hA5, constant value returned by register 15.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cs  input  1  SPI chip select, active low, already synchronous to clk.
REQ-005 SHALL have port data_ready  input  1  byte-received flag from the SPI byte slave.
REQ-006 SHALL have port received_data  input  8  received byte, valid while data_ready=1.
REQ-007 SHALL have port read_ack  output  1  one-cycle pulse that clears data_ready in the slave.
REQ-008 SHALL have port data_to_send  output  8  byte the slave shifts out next, MSB first.
REQ-009 SHALL have port status_in  input  8  live status, readable as register 14.
REQ-010 SHALL have port cfg_regs  output  112  registers 0..13 flattened; reg n at bits [8n+7:8n].

Function
REQ-011 SHALL implement states IDLE, CMD, WDATA, RDATA.
REQ-012 SHALL go to IDLE from any state in the cycle after cs=1 is sampled; partial transaction discarded, committed writes kept.
REQ-013 SHALL go IDLE->CMD when cs=0 is sampled.
REQ-014 SHALL consume a byte when data_ready=1 and read_ack was 0 in the previous cycle; consume = assert read_ack for exactly that next cycle.
REQ-015 SHALL never assert read_ack in two consecutive cycles.
REQ-016 Command byte: bit7 = 1 read / 0 write; bit6 = auto-increment; bits[5:4] ignored; bits[3:0] = start address.
REQ-017 SHALL go CMD->RDATA on a read command, CMD->WDATA on a write command.
REQ-018 WDATA: each consumed byte SHALL write the current address within 1 cycle of consumption; writes to 14 or 15 ignored.
REQ-019 RDATA: data_to_send SHALL hold the current-address value within 2 cycles of consuming the command byte and of each consumed data byte, after the address advances.
REQ-020 Read values: regs 0..13 stored value; 14 = status_in sampled at load; 15 = ID_VALUE.
REQ-021 Address SHALL advance by 1 after each consumed data byte when auto-increment=1, wrapping 15->0; otherwise it holds.
REQ-022 data_to_send SHALL be 8'h00 in IDLE, CMD and WDATA.
REQ-023 Bytes are unlimited per transaction; a cs=1 pulse is the only way to start a new command.
REQ-024 System constraint: SCK half period >= 4 clk cycles; the block does not check it.

Reset
REQ-025 While reset=1: state IDLE, cfg_regs all 0, read_ack 0, data_to_send 8'h00, address 0.
REQ-026 Reset asserted mid-transaction SHALL drop the transaction; after release, state IDLE until cs=0.

Configuration
REQ-027 Macro SPI_REG_CTRL_WSTRB_EN defined: adds wr_strobe (output 1) and wr_addr (output 4); wr_strobe pulses 1 cycle in the cycle cfg_regs updates, and wr_addr gives the written address; reset values 0.
REQ-028 Macro not defined: wr_strobe and wr_addr are absent; all other behaviour is identical.

Verification
REQ-029 cs low; bytes 8'h42, 8'h11, 8'h22, 8'h33; cs high -> regs 2,3,4 = 11,22,33; read_ack pulses 4 times, each 1 cycle.
REQ-030 cs low; bytes 8'hC2 + 3 dummy bytes -> data_to_send sequence 11, 22, 33, each within 2 cycles of the previous consume.
REQ-031 Write command 8'h4D, data 8'hAA, 8'hBB, 8'hCC -> reg 13 = AA; writes to 14 and 15 ignored; read 8'hCE -> status_in value, then A5, then reg 0.
REQ-032 Write command 8'h05, data 8'h01, 8'h02 (no auto-increment) -> reg 5 = 02, reg 6 unchanged.
REQ-033 cs high after command 8'h07 with no data byte -> no register change; next transaction sees state CMD.
REQ-034 reset pulse mid-write after 8'h40, 8'h99 -> cfg_regs all 0; with SPI_REG_CTRL_WSTRB_EN, wr_strobe 0 during reset.
